// File: rtl/endpoint_rx_model_pkg.sv
// Shared USB endpoint-Rx constants: transaction-type bit positions, SETUP layout
// and the standard request codes that the endpoint models decode.
package endpoint_rx_model_pkg;

  // i_txnType is {SETUP, OUT, IN}
  localparam int TXN_IN    = 0;
  localparam int TXN_OUT   = 1;
  localparam int TXN_SETUP = 2;

  localparam int SETUP_BYTES    = 8;
  localparam int SETUP_BREQUEST = 8;

  localparam logic [7:0] BREQUEST_GET_DESCRIPTOR = 8'h06;

  function automatic int epWidth(input int nEp);
    return (nEp > 1) ? $clog2(nEp) : 1;
  endfunction

endpackage

// File: rtl/endpoint_rx_model_pkt_fifo.sv
// First-word-fall-through FIFO; the extra pointer bit separates full from empty,
// and a pop frees a slot for a push on the same edge.
module endpoint_rx_model_pkt_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_valid,
  output logic             o_full,
  output logic [WIDTH-1:0] o_data
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wrPtr;
  logic [AW:0]      rdPtr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             empty;
  logic             doPush;
  logic             doPop;

  assign empty  = (wrPtr == rdPtr);
  assign o_full = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign doPop  = i_pop & !empty;
  assign doPush = i_push & (!o_full | doPop);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (doPush) mem[wrPtr[AW-1:0]] <= i_data;
  end

  assign o_valid = !empty;
  assign o_data  = mem[rdPtr[AW-1:0]];

endmodule

// File: rtl/endpoint_rx_model.sv
// Multi-endpoint USB endpoint-Rx sink: LFSR-driven ready/stall, per-endpoint halt,
// SETUP capture and an OUT-payload FIFO for readout.
module endpoint_rx_model
  import endpoint_rx_model_pkg::*;
#(
  parameter int          MAX_PKT    = 8,
  parameter int          N_EP       = 4,
  parameter int          DEPTH      = 4,
  parameter int          READY_DROP = 3,
  parameter int          STALL_RATE = 0,
  parameter logic [15:0] SEED       = 16'hACE1,
  localparam int         EPW        = epWidth(N_EP),
  localparam int         NBW        = $clog2(MAX_PKT) + 1,
  localparam int         DW         = 8 * MAX_PKT
) (
  input  logic            i_clk,
  input  logic            i_rst,
  output logic            o_erReady,
  input  logic            i_erValid,
  input  logic [DW-1:0]   i_erData,
  input  logic [NBW-1:0]  i_erData_nBytes,
  input  logic [2:0]      i_txnType,
  input  logic [EPW-1:0]  i_erEndp,
  output logic            o_erStall,
  input  logic [N_EP-1:0] i_haltSet,
  input  logic [N_EP-1:0] i_haltClr,
  output logic [N_EP-1:0] o_halted,
  output logic            o_setupValid,
  output logic [EPW-1:0]  o_setupEndp,
  output logic [63:0]     o_setupPkt,
  output logic            o_pktValid,
  input  logic            i_pktReady,
  output logic [DW-1:0]   o_pktData,
  output logic [NBW-1:0]  o_pktNBytes,
  output logic [EPW-1:0]  o_pktEndp,
  output logic [15:0]     o_nAccepted,
  output logic [15:0]     o_nStalled,
  output logic            o_err
);

  localparam int          FW         = DW + NBW + EPW;
  localparam bit          DROP_EN    = (READY_DROP != 0);
  localparam bit          STALL_EN   = (STALL_RATE != 0);
  localparam logic [15:0] DROP_MASK  = 16'((32'd1 << READY_DROP) - 32'd1);
  localparam logic [15:0] STALL_MASK = ~(16'hFFFF >> STALL_RATE);
  localparam logic [EPW:0] EP_LIMIT  = (EPW + 1)'(N_EP);
  localparam logic [N_EP-1:0] EP_ONE = 1;

  logic [15:0]     lfsr;
  logic [N_EP-1:0] halted;
  logic [15:0]     nAcceptedQ;
  logic [15:0]     nStalledQ;
  logic            isSetup, isOut;
  logic            epInRange, epHalted, drop, randHit;
  logic            accept, setupAcc, stallAcc, pushOut, badTxn;
  logic [N_EP-1:0] haltedShift, epSel, setVec, clrVec;
  logic            fifoValid, fifoFull;
  logic [FW-1:0]   fifoHead;
  logic [DW-1:0]   headData;
  logic [NBW-1:0]  headNBytes;
  logic [EPW-1:0]  headEndp;

  assign isSetup     = i_txnType[TXN_SETUP];
  assign isOut       = i_txnType[TXN_OUT];
  assign epInRange   = ({1'b0, i_erEndp} < EP_LIMIT);
  assign haltedShift = halted >> i_erEndp;
  assign epHalted    = epInRange & haltedShift[0];
  assign epSel       = EP_ONE << i_erEndp;
  assign drop        = DROP_EN && ((lfsr & DROP_MASK) == 16'd0);
  assign randHit     = STALL_EN && ((lfsr & STALL_MASK) == 16'd0);

  // er* handshake: a transaction is taken on the edge where o_erReady & i_erValid;
  // the source holds type/endpoint/data stable until then.
  always_comb begin
    o_erReady = !drop;
    if (isSetup)    o_erReady = 1'b1;
    else if (isOut) o_erReady = !drop & (epHalted | !fifoFull);
  end

  assign o_erStall = epHalted & !isSetup;
  assign accept    = o_erReady & i_erValid;
  assign setupAcc  = accept & isSetup;
  assign stallAcc  = accept & !isSetup & epHalted;
  assign pushOut   = accept & !isSetup & isOut & !epHalted;

  assign badTxn = !$onehot(i_txnType)
                | (i_erData_nBytes > NBW'(MAX_PKT))
                | (isSetup & (i_erData_nBytes != NBW'(SETUP_BYTES)))
                | !epInRange;

  // Clears (explicit or SETUP) win over sets (explicit or random) on the same endpoint.
  assign setVec = i_haltSet | ((pushOut & randHit) ? epSel : '0);
  assign clrVec = i_haltClr | (setupAcc ? epSel : '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      lfsr         <= SEED;
      halted       <= '0;
      nAcceptedQ   <= '0;
      nStalledQ    <= '0;
      o_err        <= 1'b0;
      o_setupValid <= 1'b0;
      o_setupEndp  <= '0;
      o_setupPkt   <= '0;
    end else begin
      lfsr         <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      halted       <= (halted | setVec) & ~clrVec;
      o_setupValid <= setupAcc;
      if (setupAcc) begin
        o_setupPkt  <= i_erData[63:0];
        o_setupEndp <= i_erEndp;
      end
      if (accept && nAcceptedQ != 16'hFFFF) nAcceptedQ <= nAcceptedQ + 16'd1;
      if (stallAcc && nStalledQ != 16'hFFFF) nStalledQ <= nStalledQ + 16'd1;
      if (accept && badTxn) o_err <= 1'b1;
    end
  end

  endpoint_rx_model_pkt_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (pushOut),
    .i_data  ({i_erData, i_erData_nBytes, i_erEndp}),
    .i_pop   (i_pktReady),
    .o_valid (fifoValid),
    .o_full  (fifoFull),
    .o_data  (fifoHead)
  );

  assign {headData, headNBytes, headEndp} = fifoHead;

  assign o_halted    = halted;
  assign o_pktValid  = fifoValid;
  assign o_pktData   = fifoValid ? headData : '0;
  assign o_pktNBytes = fifoValid ? headNBytes : '0;
  assign o_pktEndp   = fifoValid ? headEndp : '0;
  assign o_nAccepted = nAcceptedQ;
  assign o_nStalled  = nStalledQ;

endmodule
